// File: rtl/jt12_limitamp_pkg.sv
// jt12_limitamp_pkg
// Shared helpers for the parametrised limiting amplifier:
//   shw_f      - width of a shift amount able to hold 0..MAXSH
//   sat_pos_f  - most positive W-bit two's complement value (0x7F..F)
//   sat_neg_f  - most negative W-bit two's complement value (0x80..0)
//   CLIPCNT_W  - width of the optional clipped-sample counter
package jt12_limitamp_pkg;

  localparam int CLIPCNT_W = 16;

  function automatic int shw_f(input int maxsh);
    return (maxsh < 1) ? 1 : $clog2(maxsh + 1);
  endfunction

  function automatic logic [63:0] sat_pos_f(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_neg_f(input int w);
    return ~sat_pos_f(w);
  endfunction

endpackage

// File: rtl/jt12_limitamp_sat.sv
// jt12_limitamp_sat
// Combinational shift-and-saturate for one channel.
// Ports:
//   x   in  W    signed input sample
//   s   in  SHW  left shift amount (0..MAXSH)
//   y   out W    shifted sample, clamped to the W-bit signed range
//   sat out 1    high when the shifted value did not fit and was clamped
module jt12_limitamp_sat
  import jt12_limitamp_pkg::*;
#(
  parameter int W     = 16,
  parameter int MAXSH = 5,
  localparam int SHW  = shw_f(MAXSH)
) (
  input  logic signed [W-1:0] x,
  input  logic [SHW-1:0]      s,
  output logic signed [W-1:0] y,
  output logic                sat
);

  localparam int XW = W + MAXSH;
  localparam logic [W-1:0] POS = W'(sat_pos_f(W));
  localparam logic [W-1:0] NEG = W'(sat_neg_f(W));

  logic signed [XW-1:0] wide;
  logic                 fits;

  function automatic logic signed [W-1:0] sat_f(input logic signed [XW-1:0] v,
                                                input logic neg, input logic ok);
    if (ok)       return v[W-1:0];
    else if (neg) return $signed(NEG);
    else          return $signed(POS);
  endfunction

  always_comb begin
    wide = {{MAXSH{x[W-1]}}, x};
    wide = wide <<< s;
    // Fits when every bit above the W-bit sign position repeats the sign.
    fits = (&wide[XW-1:W-1]) | ~(|wide[XW-1:W-1]);
    sat  = ~fits;
    y    = sat_f(wide, x[W-1], fits);
  end

endmodule

// File: rtl/jt12_limitamp_agc.sv
// jt12_limitamp_agc
// Multichannel limiting amplifier with a linked left-shift gain, saturation
// and optional automatic gain control. Two-stage pipeline, one sample/cycle.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   in_valid    input sample strobe
//   in_data     CH*W packed signed samples, channel c at [c*W +: W]
//   gain_max    shift ceiling (values above MAXSH act as MAXSH)
//   agc_en      1 = automatic gain, 0 = static gain of gain_max
//   clip_clr    clears the sticky clip flags (and the clip counter)
//   out_valid   output strobe, two cycles after in_valid
//   out_data    shifted/saturated samples
//   cur_shift   shift currently in effect
//   clip        sticky per-channel saturation flags
//   clip_cnt    saturating clipped-sample count, present only when
//               JT12_LIMITAMP_CLIPCNT_EN is defined
module jt12_limitamp_agc
  import jt12_limitamp_pkg::*;
#(
  parameter int W     = 16,
  parameter int CH    = 2,
  parameter int MAXSH = 5,
  parameter int HOLD  = 1024,
  localparam int SHW  = shw_f(MAXSH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [CH*W-1:0]      in_data,
  input  logic [SHW-1:0]       gain_max,
  input  logic                 agc_en,
  input  logic                 clip_clr,
  output logic                 out_valid,
  output logic [CH*W-1:0]      out_data,
  output logic [SHW-1:0]       cur_shift,
  output logic [CH-1:0]        clip
`ifdef JT12_LIMITAMP_CLIPCNT_EN
  ,
  output logic [CLIPCNT_W-1:0] clip_cnt
`endif
);

  localparam int             HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [SHW-1:0] MAXSH_S   = SHW'(MAXSH);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD - 1);

  logic [SHW-1:0]  gm_clamp, s_eff;
  logic [CH*W-1:0] data_p0_q, sat_data;
  logic [SHW-1:0]  shift_p0_q, gm_p0_q;
  logic            agc_p0_q, vld_p0_q;
  logic [SHW-1:0]  cur_shift_q, cur_shift_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [CH*W-1:0] out_data_q;
  logic            out_valid_q;
  logic [CH-1:0]   sat_vec, clip_q;
  logic            any_clip;

  // In AGC mode the incoming sample must see the update of the sample now in
  // stage 2, so it takes the next-state shift rather than the register.
  always_comb begin
    gm_clamp = (gain_max > MAXSH_S) ? MAXSH_S : gain_max;
    s_eff    = agc_en ? cur_shift_d : gm_clamp;
  end

  // ---- stage 1: capture sample, its shift and its control context ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p0_q <= 1'b0;
    else        vld_p0_q <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      data_p0_q  <= in_data;
      shift_p0_q <= s_eff;
      gm_p0_q    <= gm_clamp;
      agc_p0_q   <= agc_en;
    end
  end

  // ---- stage 2: shift/saturate, clip flags and AGC update ----
  for (genvar c = 0; c < CH; c++) begin : g_ch
    jt12_limitamp_sat #(.W(W), .MAXSH(MAXSH)) u_sat (
      .x   (data_p0_q[c*W +: W]),
      .s   (shift_p0_q),
      .y   (sat_data[c*W +: W]),
      .sat (sat_vec[c])
    );
  end

  always_comb begin
    any_clip    = |sat_vec;
    cur_shift_d = cur_shift_q;
    hold_d      = hold_q;
    if (vld_p0_q) begin
      if (!agc_p0_q) begin
        cur_shift_d = shift_p0_q;
        hold_d      = '0;
      end else if (cur_shift_q > gm_p0_q) begin
        // Ceiling was lowered under us: snap down, restart the clean count.
        cur_shift_d = gm_p0_q;
        hold_d      = '0;
      end else if (any_clip) begin
        hold_d = '0;
        if (cur_shift_q != '0) cur_shift_d = cur_shift_q - 1'b1;
      end else if (hold_q == HOLD_LAST) begin
        hold_d = '0;
        if (cur_shift_q < gm_p0_q) cur_shift_d = cur_shift_q + 1'b1;
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cur_shift_q <= '0;
      hold_q      <= '0;
      clip_q      <= '0;
    end else begin
      out_valid_q <= vld_p0_q;
      if (vld_p0_q) out_data_q <= sat_data;
      cur_shift_q <= cur_shift_d;
      hold_q      <= hold_d;
      // Clear first, then OR in new saturation so a same-cycle set wins.
      clip_q      <= (clip_clr ? '0 : clip_q) | (vld_p0_q ? sat_vec : '0);
    end
  end

`ifdef JT12_LIMITAMP_CLIPCNT_EN
  logic [CLIPCNT_W-1:0] clip_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clip_cnt_q <= '0;
    end else if (vld_p0_q && any_clip) begin
      if (clip_clr)         clip_cnt_q <= CLIPCNT_W'(1);
      else if (!(&clip_cnt_q)) clip_cnt_q <= clip_cnt_q + 1'b1;
    end else if (clip_clr) begin
      clip_cnt_q <= '0;
    end
  end

  assign clip_cnt = clip_cnt_q;
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign cur_shift = cur_shift_q;
  assign clip      = clip_q;

endmodule

// File: tb/tb_jt12_limitamp_agc.sv
// tb_jt12_limitamp_agc
// Randomized and directed stimulus against a per-sample behavioural model of
// the limiting amplifier (W=16, CH=2, MAXSH=5, HOLD=4).
// Set JT12_LIMITAMP_CLIPCNT_EN to also check clip_cnt.
module tb_jt12_limitamp_agc;
  localparam int W = 16, CH = 2, MAXSH = 5, HOLD = 4;

  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
  logic        agc_en = 1'b0, clip_clr = 1'b0;
  logic [31:0] in_data = '0;
  logic [2:0]  gain_max = '0;
  logic        out_valid;
  logic [31:0] out_data;
  logic [2:0]  cur_shift;
  logic [1:0]  clip;
`ifdef JT12_LIMITAMP_CLIPCNT_EN
  logic [15:0] clip_cnt;
`endif

  always #5 clk = ~clk;

  jt12_limitamp_agc #(.W(W), .CH(CH), .MAXSH(MAXSH), .HOLD(HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .gain_max  (gain_max),
    .agc_en    (agc_en),
    .clip_clr  (clip_clr),
    .out_valid (out_valid),
    .out_data  (out_data),
    .cur_shift (cur_shift),
    .clip      (clip)
`ifdef JT12_LIMITAMP_CLIPCNT_EN
    ,
    .clip_cnt  (clip_cnt)
`endif
  );

  typedef struct {
    int          stamp;
    logic [31:0] data;
    logic [1:0]  sat;
    logic [2:0]  cur;
  } exp_t;

  exp_t       q[$];
  int         m_cur = 0, m_clean = 0, m_cnt = 0, m_vis_cur = 0;
  logic [1:0] m_clip = '0;
  int         ncyc = 0, n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Per-sample model in presentation order: gain = multiply by 2**s.
  task automatic model_push(input logic [15:0] l, input logic [15:0] r,
                            input logic [2:0] gm_raw, input logic agc);
    int          gm, s;
    longint      v;
    logic [15:0] x[2];
    logic [15:0] y;
    exp_t        e;
    gm = (int'(gm_raw) > MAXSH) ? MAXSH : int'(gm_raw);
    s  = agc ? m_cur : gm;
    x[0] = l; x[1] = r;
    e.sat = '0; e.data = '0;
    for (int c = 0; c < 2; c++) begin
      v = longint'($signed(x[c])) * (longint'(1) << s);
      if (v > 32767)       begin y = 16'h7FFF; e.sat[c] = 1'b1; end
      else if (v < -32768) begin y = 16'h8000; e.sat[c] = 1'b1; end
      else                 y = v[15:0];
      e.data[c*16 +: 16] = y;
    end
    if (!agc) begin
      m_cur = s; m_clean = 0;
    end else if (m_cur > gm) begin
      m_cur = gm; m_clean = 0;
    end else if (|e.sat) begin
      m_clean = 0;
      if (m_cur > 0) m_cur--;
    end else begin
      m_clean++;
      if (m_clean == HOLD) begin
        m_clean = 0;
        if (m_cur < gm) m_cur++;
      end
    end
    e.cur   = m_cur[2:0];
    e.stamp = ncyc;
    q.push_back(e);
  endtask

  task automatic monitor(input logic clr_e);
    logic exp_v;
    exp_t e;
    exp_v = (q.size() > 0) && (q[0].stamp == ncyc - 1);
    chk("out_valid", 32'(out_valid), 32'(exp_v));
    if (clr_e) begin m_clip = '0; m_cnt = 0; end
    if (exp_v && out_valid) begin
      e = q.pop_front();
      chk("out_data", out_data, e.data);
      chk("cur_shift", 32'(cur_shift), 32'(e.cur));
      m_clip |= e.sat;
      if (|e.sat) m_cnt = (m_cnt == 65535) ? 65535 : m_cnt + 1;
      m_vis_cur = int'(e.cur);
    end else begin
      if (exp_v) void'(q.pop_front());
      chk("cur_shift_idle", 32'(cur_shift), 32'(m_vis_cur));
    end
    chk("clip", 32'(clip), 32'(m_clip));
`ifdef JT12_LIMITAMP_CLIPCNT_EN
    chk("clip_cnt", 32'(clip_cnt), 32'(m_cnt));
`endif
  endtask

  task automatic step(input logic v, input logic [15:0] l, input logic [15:0] r,
                      input logic [2:0] gm, input logic agc, input logic clr);
    logic clr_e;
    in_valid = v; in_data = {r, l}; gain_max = gm; agc_en = agc; clip_clr = clr;
    if (v) model_push(l, r, gm, agc);
    @(posedge clk);
    clr_e = clip_clr;
    @(negedge clk);
    monitor(clr_e);
    ncyc++;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0; in_valid = 1'b0; clip_clr = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_cur_shift", 32'(cur_shift), 32'd0);
    chk("rst_clip", 32'(clip), 32'd0);
`ifdef JT12_LIMITAMP_CLIPCNT_EN
    chk("rst_clip_cnt", 32'(clip_cnt), 32'd0);
`endif
    q.delete();
    m_cur = 0; m_clean = 0; m_clip = '0; m_cnt = 0; m_vis_cur = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_step();
    logic signed [15:0] l, r;
    l = 16'($urandom); r = 16'($urandom);
    l = l >>> ($urandom % 16);
    r = r >>> ($urandom % 16);
    step(($urandom % 4) != 0, l, r, 3'($urandom % 8), ($urandom % 8) != 0,
         ($urandom % 20) == 0);
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Static gain
    step(1, 16'h0100, 16'hFF00, 3'd5, 1'b0, 1'b0);
    step(0, 16'h0, 16'h0, 3'd5, 1'b0, 1'b0);
    chk("static_data", out_data, 32'hE000_2000);
    chk("static_clip", 32'(clip), 32'd0);

    // Saturation
    step(1, 16'h0400, 16'hFBFF, 3'd5, 1'b0, 1'b0);
    step(0, 16'h0, 16'h0, 3'd5, 1'b0, 1'b0);
    chk("sat_data", out_data, 32'h8000_7FFF);
    chk("sat_clip", 32'(clip), 32'd3);
`ifdef JT12_LIMITAMP_CLIPCNT_EN
    chk("sat_cnt", 32'(clip_cnt), 32'd1);
`endif

    // AGC attack from shift 5
    repeat (3) step(1, 16'h0800, 16'h0, 3'd5, 1'b1, 1'b0);
    step(0, 16'h0, 16'h0, 3'd5, 1'b1, 1'b0);
    chk("attack_data", out_data, 32'h0000_4000);
    chk("attack_shift", 32'(cur_shift), 32'd3);

    // AGC release: HOLD consecutive clean samples raise the shift
    repeat (3) step(1, 16'h0100, 16'h0, 3'd5, 1'b1, 1'b0);
    step(0, 16'h0, 16'h0, 3'd5, 1'b1, 1'b0);
    chk("release_shift", 32'(cur_shift), 32'd4);
    repeat (4) step(1, 16'h0100, 16'h0, 3'd4, 1'b1, 1'b0);
    step(0, 16'h0, 16'h0, 3'd4, 1'b1, 1'b0);
    chk("ceiling_hold", 32'(cur_shift), 32'd4);
    step(1, 16'h0100, 16'h0, 3'd2, 1'b1, 1'b0);
    step(0, 16'h0, 16'h0, 3'd2, 1'b1, 1'b0);
    chk("ceiling_lower", 32'(cur_shift), 32'd2);

    // Clip clear colliding with a clipping stage-2 sample, then clear alone
    step(1, 16'h0400, 16'hFBFF, 3'd5, 1'b0, 1'b0);
    step(0, 16'h0, 16'h0, 3'd5, 1'b0, 1'b1);
    chk("clr_set_clip", 32'(clip), 32'd3);
`ifdef JT12_LIMITAMP_CLIPCNT_EN
    chk("clr_set_cnt", 32'(clip_cnt), 32'd1);
`endif
    step(0, 16'h0, 16'h0, 3'd5, 1'b0, 1'b1);
    chk("clr_only_clip", 32'(clip), 32'd0);
`ifdef JT12_LIMITAMP_CLIPCNT_EN
    chk("clr_only_cnt", 32'(clip_cnt), 32'd0);
`endif

    // Randomized traffic
    repeat (800) rand_step();

    // Reset with samples in flight; nothing may emerge afterwards
    step(1, 16'h1234, 16'h8765, 3'd3, 1'b0, 1'b0);
    step(1, 16'h0400, 16'hFBFF, 3'd5, 1'b0, 1'b0);
    do_reset();
    repeat (2) step(0, 16'h0, 16'h0, 3'd5, 1'b1, 1'b0);
    repeat (100) rand_step();
    repeat (2) step(0, 16'h0, 16'h0, 3'd5, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
